// File: rtl/sint_accum.sv
// sint_accum: sums DEPTH signed WIDTH-bit samples per frame and reports the sum plus a sticky overflow flag.
// Latency: the result is valid on the first edge after the frame's last sample is accepted.
// Backpressure: one result is held; I_ready stays low while O_valid is high, until O_ready takes the result.
// Ports: CLK, RESET (sync, active-high); I_valid/I_ready/I_data in; O_valid/O_ready/O_data/O_overflow out.
// Build option: define SINT_ACCUM_SAT_EN to saturate overflowing additions instead of wrapping.
module sint_accum #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_valid,
  output logic             I_ready,
  input  logic [WIDTH-1:0] I_data,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [WIDTH-1:0] O_data,
  output logic             O_overflow
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic {ACC, OUT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;      // sticky flag of the frame in progress
  logic [WIDTH-1:0] odata_q, odata_d;
  logic             oovf_q, oovf_d;

  logic [WIDTH-1:0] sum_raw;
  logic [WIDTH-1:0] sum;
  logic             ovf_add;
  logic             in_xfer;
  logic             out_xfer;

  // Overflow: equal operand signs and a result sign that differs from them.
  always_comb begin
    sum_raw = acc_q + I_data;
    ovf_add = (acc_q[WIDTH-1] == I_data[WIDTH-1]) && (sum_raw[WIDTH-1] != acc_q[WIDTH-1]);
  end

`ifdef SINT_ACCUM_SAT_EN
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  // Direction of the overflow follows the common operand sign.
  always_comb begin
    sum = sum_raw;
    if (ovf_add) begin
      sum = acc_q[WIDTH-1] ? MIN_V : MAX_V;
    end
  end
`else
  always_comb begin
    sum = sum_raw;
  end
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    odata_d  = odata_q;
    oovf_d   = oovf_q;
    I_ready  = (state_q == ACC);
    O_valid  = (state_q == OUT);
    in_xfer  = I_valid && I_ready;
    out_xfer = O_valid && O_ready;

    case (state_q)
      ACC: begin
        if (in_xfer) begin
          if (cnt_q == LAST) begin
            // Last sample: publish the result and start a clean frame.
            odata_d = sum;
            oovf_d  = ovf_q | ovf_add;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = OUT;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
            ovf_d = ovf_q | ovf_add;
          end
        end
      end
      OUT: begin
        if (out_xfer) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      odata_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      odata_q <= odata_d;
      oovf_q  <= oovf_d;
    end
  end

  assign O_data     = odata_q;
  assign O_overflow = oovf_q;

endmodule

// File: tb/tb_sint_accum.sv
// tb_sint_accum: directed stimulus for sint_accum (WIDTH=8, DEPTH=4) with an integer-arithmetic frame model.
// The model follows the transfer rules at each rising edge; outputs are compared on every falling edge.
// Literal expectations for each directed frame are checked as well.
module tb_sint_accum;

  localparam int W = 8;
  localparam int D = 4;
  localparam int MAXV = 127;
  localparam int MINV = -128;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         I_valid = 1'b0;
  logic         I_ready;
  logic [W-1:0] I_data = '0;
  logic         O_valid;
  logic         O_ready = 1'b1;
  logic [W-1:0] O_data;
  logic         O_overflow;

  int checks = 0;
  int errors = 0;

  sint_accum #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_valid(I_valid), .I_ready(I_ready), .I_data(I_data),
    .O_valid(O_valid), .O_ready(O_ready), .O_data(O_data), .O_overflow(O_overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  samples[$];
  bit  m_pending = 1'b0;
  int  m_data = 0;
  bit  m_ovf = 1'b0;

  // Plain integer sum with range checks; wrap or clamp per build.
  task automatic frame_result(output int r, output bit o);
    int a;
    int s;
    a = 0;
    o = 1'b0;
    foreach (samples[i]) begin
      s = a + samples[i];
      if (s > MAXV || s < MINV) o = 1'b1;
`ifdef SINT_ACCUM_SAT_EN
      if (s > MAXV) s = MAXV;
      else if (s < MINV) s = MINV;
`else
      s = ((s + 384) % 256) - 128;
`endif
      a = s;
    end
    r = a;
  endtask

  always @(posedge CLK) begin
    if (RESET) begin
      m_pending = 1'b0;
      samples.delete();
      m_data = 0;
      m_ovf = 1'b0;
    end else if (m_pending) begin
      if (O_ready) m_pending = 1'b0;
    end else if (I_valid) begin
      samples.push_back(int'($signed(I_data)));
      if (samples.size() == D) begin
        frame_result(m_data, m_ovf);
        samples.delete();
        m_pending = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    chk("i_ready", int'(I_ready), int'(!m_pending));
    chk("o_valid", int'(O_valid), int'(m_pending));
    if (m_pending) begin
      chk("o_data", int'($signed(O_data)), m_data);
      chk("o_overflow", int'(O_overflow), int'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one sample and hold it until it is accepted.
  task automatic send(input int x);
    int n;
    n = 0;
    I_valid = 1'b1;
    I_data  = W'(x);
    while (!I_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout actual=%0d expected=%0d", n, 0);
    end
    step();
    I_valid = 1'b0;
  endtask

  // Sends four samples; the result must be present right after the last acceptance.
  task automatic frame4(input string nm, input int a, input int b, input int c, input int d,
                        input int exp_d, input bit exp_o);
    send(a);
    send(b);
    send(c);
    send(d);
    chk({nm, "_latency"}, int'(O_valid), 1);
    chk({nm, "_data"}, int'($signed(O_data)), exp_d);
    chk({nm, "_ovf"}, int'(O_overflow), int'(exp_o));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=%0d expected=%0d", checks, 0);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    chk("rst_i_ready", int'(I_ready), 1);
    chk("rst_o_valid", int'(O_valid), 0);
    chk("rst_o_data", int'(O_data), 0);
    chk("rst_o_ovf", int'(O_overflow), 0);

    // Basic sum, single-cycle output pulse with O_ready high
    O_ready = 1'b1;
    frame4("sum10", 1, 2, 3, 4, 10, 1'b0);
    step();
    chk("sum10_pulse", int'(O_valid), 0);

    // Positive and negative overflow
`ifdef SINT_ACCUM_SAT_EN
    frame4("pos_ovf", 100, 100, 0, 0, 127, 1'b1);
    step();
    frame4("neg_ovf", -128, -1, 0, 0, -128, 1'b1);
    step();
    frame4("chain", 127, 1, -1, 0, 126, 1'b1);
`else
    frame4("pos_ovf", 100, 100, 0, 0, -56, 1'b1);
    step();
    frame4("neg_ovf", -128, -1, 0, 0, 127, 1'b1);
    step();
    frame4("chain", 127, 1, -1, 0, 127, 1'b1);
`endif
    step();

    // Backpressure: result held, input ignored, then released
    O_ready = 1'b0;
    frame4("hold", 1, 1, 1, 1, 4, 1'b0);
    I_valid = 1'b1;
    I_data  = W'(99);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_data", int'($signed(O_data)), 4);
      chk("hold_i_ready", int'(I_ready), 0);
      chk("hold_o_valid", int'(O_valid), 1);
    end
    I_valid = 1'b0;
    O_ready = 1'b1;
    step();
    chk("release_i_ready", int'(I_ready), 1);
    chk("release_o_valid", int'(O_valid), 0);

    // Reset mid-frame discards the partial sum
    send(5);
    send(5);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    frame4("after_rst", 1, 1, 1, 1, 4, 1'b0);
    step();

    // Reset while a result is pending discards it
    O_ready = 1'b0;
    frame4("pend", 10, 20, 30, 40, 100, 1'b0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("pend_rst_o_valid", int'(O_valid), 0);
    chk("pend_rst_o_data", int'(O_data), 0);
    O_ready = 1'b1;

    // Sparse input: valid every other cycle
    I_valid = 1'b1; I_data = W'(-3); step(); I_valid = 1'b0; step();
    I_valid = 1'b1; I_data = W'(7);  step(); I_valid = 1'b0; step();
    I_valid = 1'b1; I_data = W'(-2); step(); I_valid = 1'b0; step();
    I_valid = 1'b1; I_data = W'(1);  step(); I_valid = 1'b0;
    chk("sparse_latency", int'(O_valid), 1);
    chk("sparse_data", int'($signed(O_data)), 3);
    chk("sparse_ovf", int'(O_overflow), 0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sint_accum.md
SINT_ACCUM -- requirements
Module: sint_accum

Interface
REQ-001 Parameter WIDTH, default 8: signed two's-complement operand and result width, WIDTH >= 2.
REQ-002 Parameter DEPTH, default 4: input samples summed per frame, DEPTH >= 1.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 I_valid  input  1  I_data is valid.
REQ-006 I_ready  output  1  block accepts I_data this cycle.
REQ-007 I_data  input  WIDTH  signed input sample.
REQ-008 O_valid  output  1  O_data and O_overflow hold a completed frame result.
REQ-009 O_ready  input  1  downstream accepts the result.
REQ-010 O_data  output  WIDTH  signed frame sum.
REQ-011 O_overflow  output  1  at least one addition in the frame overflowed.

Function
REQ-012 A transfer occurs on a rising edge where valid and ready of the same channel are both high; there is no other transfer.
REQ-013 The FSM has two states. ACC: I_ready=1, O_valid=0. OUT: I_ready=0, O_valid=1.
REQ-014 In ACC, each input transfer sets acc <= acc (+) I_data and cnt <= cnt+1, where (+) is the WIDTH-bit add defined in REQ-019/020.
REQ-015 An input transfer with cnt == DEPTH-1 loads O_data with acc (+) I_data, clears acc and cnt, and moves to OUT.
REQ-016 Latency: O_valid rises on the first edge after the last sample of the frame is accepted.
REQ-017 In OUT, O_data and O_overflow hold stable until an output transfer, which moves the FSM to ACC.
REQ-018 Input and output transfers never occur in the same cycle. The block holds one frame result and accepts no input while it is in OUT.
REQ-019 Overflow on an addition occurs when both operands have equal signs and the WIDTH-bit sum has the opposite sign.
REQ-020 The overflow flag is sticky across the frame, is reported with the result, and is cleared at the start of the next frame.
REQ-021 With DEPTH=1, every accepted sample produces a result equal to 0 (+) I_data; O_overflow is 0.
REQ-022 cnt is max(1, clog2(DEPTH)) bits wide and never exceeds DEPTH-1.

Reset
REQ-023 When RESET=1, the FSM goes to ACC, and acc, cnt, O_data and the sticky flag are set to 0.
REQ-024 Outputs after reset: I_ready=1, O_valid=0, O_data=0, O_overflow=0.
REQ-025 RESET asserted mid-frame or in OUT discards the partial or pending result. No transfer is counted on an edge where RESET=1.

Configuration
REQ-026 Macro SINT_ACCUM_SAT_EN.
- Defined: an overflowing addition saturates to +(2^(WIDTH-1))-1 for a positive overflow, or to -2^(WIDTH-1) for a negative overflow.
- Not defined: additions wrap modulo 2^WIDTH.
- O_overflow behaves identically in both builds.

Verification (WIDTH=8, DEPTH=4)
REQ-027 Inputs 1, 2, 3, 4 with O_ready=1 -> O_valid for exactly 1 cycle, O_data=10, O_overflow=0.
REQ-028 Inputs 100, 100, 0, 0 -> without the macro: O_data=-56, O_overflow=1. With SINT_ACCUM_SAT_EN: O_data=127, O_overflow=1.
REQ-029 Inputs -128, -1, 0, 0 -> without the macro: O_data=127, O_overflow=1. With SINT_ACCUM_SAT_EN: O_data=-128, O_overflow=1.
REQ-030 After a completed frame, O_ready=0 for 3 cycles -> O_data stable, I_ready=0, I_valid ignored. Then O_ready=1 -> 1 transfer, I_ready=1 on the next cycle.
REQ-031 Accept 5, 5, then RESET for 1 cycle, then inputs 1, 1, 1, 1 -> O_data=4, O_overflow=0.
REQ-032 I_valid toggled every other cycle with values -3, 7, -2, 1 -> O_data=3; the result appears 1 cycle after the 4th accepted sample.
